// File: rtl/scaler_coe_rom.sv
// Catmull-Rom (a=-0.5) 4-tap coefficient ROM, 32 phases, registered read.
// Optional macro SCALER_COE_ROM_OREG_EN adds a second output register stage (latency 2).
module scaler_coe_rom #(
    parameter int COE_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           addr,
    output logic [COE_WIDTH-1:0] rom0_do,
    output logic [COE_WIDTH-1:0] rom1_do,
    output logic [COE_WIDTH-1:0] rom2_do,
    output logic [COE_WIDTH-1:0] rom3_do
);

    localparam int W       = COE_WIDTH;
    localparam int ENTRY_W = 4 * W;

    typedef logic [32*ENTRY_W-1:0] table_t;

    // Each weight is S * poly(k) / 65536 with integer poly; adding 32768 before
    // the divide rounds half up. Entry layout per phase is {rom0, rom1, rom2, rom3}.
    function automatic table_t build_table();
        table_t tbl;
        longint s;
        longint k;
        longint m;
        longint n0;
        longint n1;
        longint n2;
        longint n3;
        tbl = '0;
        s   = longint'(1) << (W - 1);
        for (int i = 0; i < 32; i++) begin
            k  = longint'(i);
            m  = 32 - k;
            n0 = s * k * m * m;
            n1 = s * (3 * k * k * k - 160 * k * k + 65536);
            n2 = s * (-3 * k * k * k + 128 * k * k + 1024 * k);
            n3 = s * k * k * m;
            tbl[i*ENTRY_W + 3*W +: W] = W'((n0 + 32768) / 65536);
            tbl[i*ENTRY_W + 2*W +: W] = W'((n1 + 32768) / 65536);
            tbl[i*ENTRY_W + 1*W +: W] = W'((n2 + 32768) / 65536);
            tbl[i*ENTRY_W + 0*W +: W] = W'((n3 + 32768) / 65536);
        end
        return tbl;
    endfunction

    localparam table_t COE_TABLE = build_table();

    logic [ENTRY_W-1:0] tap_d;
    logic [ENTRY_W-1:0] tap_q = '0;
    logic [ENTRY_W-1:0] out_word;
    logic               unused_addr_hi;

    // Only the phase bits select an entry; upper address bits wrap to the same phase.
    assign unused_addr_hi = ^addr[9:5];

    always_comb begin
        tap_d = COE_TABLE[int'(addr[4:0])*ENTRY_W +: ENTRY_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end

`ifdef SCALER_COE_ROM_OREG_EN
    logic [ENTRY_W-1:0] oreg_d;
    logic [ENTRY_W-1:0] oreg_q = '0;

    always_comb begin
        oreg_d = tap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oreg_q <= '0;
        end else begin
            oreg_q <= oreg_d;
        end
    end

    assign out_word = oreg_q;
`else
    assign out_word = tap_q;
`endif

    assign rom0_do = out_word[3*W +: W];
    assign rom1_do = out_word[2*W +: W];
    assign rom2_do = out_word[1*W +: W];
    assign rom3_do = out_word[0*W +: W];

endmodule

// File: tb/tb_scaler_coe_rom.sv
// Self-checking bench for scaler_coe_rom: scoreboard of expected tap words, independent real-valued model.
module tb_scaler_coe_rom;

    localparam int W = 10;
`ifdef SCALER_COE_ROM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   addr = '0;
    logic [W-1:0] rom0_do;
    logic [W-1:0] rom1_do;
    logic [W-1:0] rom2_do;
    logic [W-1:0] rom3_do;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [4*W-1:0] exp_q[$];
    int             due_q[$];
    int             sweep_q[$];
    string          tag_q[$];

    logic [W-1:0] obs0[32];
    logic [W-1:0] obs1[32];
    logic [W-1:0] obs2[32];
    logic [W-1:0] obs3[32];
    logic         seen[32];

    scaler_coe_rom #(.COE_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rom0_do (rom0_do),
        .rom1_do (rom1_do),
        .rom2_do (rom2_do),
        .rom3_do (rom3_do)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input int a, input int b, input int c, input int d);
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] wc;
        logic [W-1:0] wd;
        wa = W'(a);
        wb = W'(b);
        wc = W'(c);
        wd = W'(d);
        return {wa, wb, wc, wd};
    endfunction

    function automatic int rnd(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic logic [4*W-1:0] model(input int k);
        real t;
        real s;
        t = k / 32.0;
        s = 2.0 ** (W - 1);
        return pk(rnd(s * 0.5 * t * (1.0 - t) * (1.0 - t)),
                  rnd(s * (1.5 * t * t * t - 2.5 * t * t + 1.0)),
                  rnd(s * (-1.5 * t * t * t + 2.0 * t * t + 0.5 * t)),
                  rnd(s * 0.5 * t * t * (1.0 - t)));
    endfunction

    // Drive one cycle; a reset zeroes everything still held in the pipeline.
    task automatic drive(input logic [9:0] a, input logic r, input logic [4*W-1:0] e,
                         input int sidx, input string tag);
        @(posedge clk);
        #2;
        addr = a;
        rst  = r;
        if (r) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (due_q[i] >= cyc + 1) exp_q[i] = '0;
            end
        end
        exp_q.push_back(r ? '0 : e);
        due_q.push_back(cyc + LAT);
        sweep_q.push_back(sidx);
        tag_q.push_back(tag);
    endtask

    // scoreboard: compare on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            logic [4*W-1:0] e;
            int             d;
            int             s;
            string          tg;
            e  = exp_q.pop_front();
            d  = due_q.pop_front();
            s  = sweep_q.pop_front();
            tg = tag_q.pop_front();
            check((d == cyc) ? tg : {tg, "_late"}, {rom0_do, rom1_do, rom2_do, rom3_do}, e);
            if (s >= 0) begin
                obs0[s] = rom0_do;
                obs1[s] = rom1_do;
                obs2[s] = rom2_do;
                obs3[s] = rom3_do;
                seen[s] = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        #1;
        check("powerup", {rom0_do, rom1_do, rom2_do, rom3_do}, '0);

        drive(10'd5, 1'b1, '0, -1, "reset0");
        drive(10'd9, 1'b1, '0, -1, "reset1");

        drive(10'd0,  1'b0, pk(0, 512, 0, 0),     -1, "addr0");
        drive(10'd8,  1'b0, pk(36, 444, 116, 12), -1, "addr8");
        drive(10'd16, 1'b0, pk(32, 288, 288, 32), -1, "addr16");
        drive(10'd0,  1'b0, pk(0, 512, 0, 0),     -1, "b2b_0");
        drive(10'd16, 1'b0, pk(32, 288, 288, 32), -1, "b2b_16");
        drive(10'd8,  1'b0, pk(36, 444, 116, 12), -1, "b2b_8");
        drive(10'h3F0, 1'b0, pk(32, 288, 288, 32), -1, "addr3f0");
        drive(10'd32, 1'b0, pk(0, 512, 0, 0),     -1, "addr32");

        for (int k = 0; k < 32; k++) begin
            logic [9:0] a;
            a = {5'($urandom_range(0, 31)), 5'(k)};
            drive(a, 1'b0, model(k), k, $sformatf("sweep%0d", k));
        end

        for (int i = 0; i < 30; i++) begin
            logic [9:0] a;
            a = 10'($urandom_range(0, 1023));
            drive(a, 1'b0, model(int'(a[4:0])), -1, "random");
        end

        drive(10'd8,  1'b0, pk(36, 444, 116, 12), -1, "pre_rst");
        drive(10'd16, 1'b1, '0, -1, "rst_mid");
        drive(10'd16, 1'b0, pk(32, 288, 288, 32), -1, "rst_release");
        drive(10'd8,  1'b0, pk(36, 444, 116, 12), -1, "post_rst");

        for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_timeout", 64'(due_q.size()), 64'd0);

        for (int k = 0; k < 32; k++) begin
            int diff;
            check($sformatf("swept%0d", k), 64'(seen[k]), 64'd1);
            diff = int'(obs1[k]) + int'(obs2[k]) - int'(obs0[k]) - int'(obs3[k]) - 512;
            check($sformatf("gain%0d", k), 64'(diff >= -2 && diff <= 2), 64'd1);
            if (k >= 1) begin
                check($sformatf("sym3_%0d", k), 64'(obs3[k]), 64'(obs0[32-k]));
                check($sformatf("sym2_%0d", k), 64'(obs2[k]), 64'(obs1[32-k]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
